// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller in front of the UART transmitter.
// Bytes are queued from the bus side and handed out one at a time, paced by tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    din,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_din,
    output logic          tx_wr_en,
    input  logic          tx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    state_t      state;
    state_t      next_state;
    logic        launch;
    logic        push;

    // One extra pointer bit distinguishes full from empty when the indices match.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_W);
    assign empty = (count == '0);
    assign push  = wr_en && !full && !flush;

    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    launch     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Flush moves rd_ptr only; an in-flight launch is left to finish.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_wr_en <= 1'b0;
            tx_din   <= 8'h00;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= next_state;
            tx_wr_en <= launch;
            overflow <= wr_en && full && !flush;
            if (launch) begin
                tx_din <= mem[rd_ptr[AW-1:0]];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
